univ_shift_reg: RTL

//  Parametrised successor to the single-bit d_ff: a WIDTH-bit universal register.

---
 rtl/univ_shift_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, load, shift, rotate and clear.
// It also keeps a saturating count of bit positions shifted out since the last load or clear.
package univ_shift_reg_pkg;
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROTL = 3'b100,
    M_ROTR = 3'b101,
    M_CLR  = 3'b110,
    M_RSVD = 3'b111
  } mode_e;
endpackage

// One register bit. The top level wires in the neighbour that each mode selects.
module usr_bit_cell
  import univ_shift_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       d,
  input  logic       rst_val,
  input  logic       shl_src,
  input  logic       shr_src,
  input  logic       rotl_src,
  input  logic       rotr_src,
  output logic       q
);
  logic nxt;

  // Unlisted and unknown codes fall through to the default and hold the bit.
  always_comb begin
    nxt = q;
    case (mode)
      M_LOAD:  nxt = d;
      M_SHL:   nxt = shl_src;
      M_SHR:   nxt = shr_src;
      M_ROTL:  nxt = rotl_src;
      M_ROTR:  nxt = rotr_src;
      M_CLR:   nxt = rst_val;
      default: nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)    q <= rst_val;
    else if (en) q <= nxt;
  end
endmodule

module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             flushed
);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] shl_v, shr_v, rotl_v, rotr_v;
  logic [CW-1:0]    cnt_next;

  assign shl_v  = {q[WIDTH-2:0], sin_r};
  assign shr_v  = {sin_l, q[WIDTH-1:1]};
  assign rotl_v = {q[WIDTH-2:0], q[WIDTH-1]};
  assign rotr_v = {q[0], q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .d        (d[i]),
      .rst_val  (RST_VAL[i]),
      .shl_src  (shl_v[i]),
      .shr_src  (shr_v[i]),
      .rotl_src (rotl_v[i]),
      .rotr_src (rotr_v[i]),
      .q        (q[i])
    );
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  // Both shift directions count; rotates lose no data, so they leave the count alone.
  always_comb begin
    cnt_next = cnt;
    case (mode)
      M_LOAD, M_CLR: cnt_next = '0;
      M_SHL, M_SHR:  cnt_next = (cnt < CNT_MAX) ? cnt + 1'b1 : CNT_MAX;
      default:       cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      flushed <= 1'b0;
    end else if (en) begin
      cnt     <= cnt_next;
      flushed <= (cnt_next == CNT_MAX);
    end
  end
endmodule
